// File: rtl/led_activity_blinker.sv
// Turns each edge of an asynchronous activity level into one visible LED blink (ON, then forced dark gap).
// Optional build macro LED_PWM_EN adds a 4-bit duty_i input that dims the LED during ON.
module led_activity_blinker #(
    parameter int PRESCALE  = 4,
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 3,
    parameter int MISS_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              act_i,
`ifdef LED_PWM_EN
    input  logic [3:0]        duty_i,
`endif
    output logic              led_o,
    output logic              busy_o,
    output logic              pending_o,
    output logic [MISS_W-1:0] missed_o
);

    localparam int PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int DUR_W     = $clog2(MAX_TICKS + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} state_t;

    function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
        return (&v) ? v : v + MISS_W'(1);
    endfunction

    logic              s1, s2, s2_d;
    logic [2:0]        arm_sr;
    logic              evt;
    logic [PRE_W-1:0]  presc;
    logic [DUR_W-1:0]  dur;
    logic              tick, on_done, off_done;
    state_t            state, state_nxt;
    logic              entry;
    logic              pend_nxt;
    logic [MISS_W-1:0] miss_nxt;
`ifdef LED_PWM_EN
    logic [3:0]        pwm_cnt;
`endif

    // Arming lags the synchroniser by one stage so a level already high at reset release is not an edge
    assign evt      = arm_sr[2] & (s2 ^ s2_d);
    assign tick     = (presc == PRE_W'(PRESCALE - 1));
    assign on_done  = tick && (dur == DUR_W'(ON_TICKS - 1));
    assign off_done = tick && (dur == DUR_W'(OFF_TICKS - 1));

    always_comb begin
        state_nxt = state;
        entry     = 1'b0;
        pend_nxt  = pending_o;
        miss_nxt  = missed_o;
        case (state)
            ST_IDLE: begin
                if (evt) begin
                    state_nxt = ST_ON;
                    entry     = 1'b1;
                end
            end
            ST_ON: begin
                if (on_done) begin
                    state_nxt = ST_OFF;
                    entry     = 1'b1;
                end
                if (evt) begin
                    if (pending_o) miss_nxt = sat_inc(missed_o);
                    else           pend_nxt = 1'b1;
                end
            end
            ST_OFF: begin
                if (off_done) begin
                    entry = 1'b1;
                    // A queued event and a fresh one can both be honoured: one starts now, one waits
                    if (pending_o || evt) begin
                        state_nxt = ST_ON;
                        pend_nxt  = pending_o & evt;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (evt) begin
                    if (pending_o) miss_nxt = sat_inc(missed_o);
                    else           pend_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                entry     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s2_d      <= 1'b0;
            arm_sr    <= '0;
            state     <= ST_IDLE;
            pending_o <= 1'b0;
            missed_o  <= '0;
            presc     <= '0;
            dur       <= '0;
            led_o     <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            s1        <= act_i;
            s2        <= s1;
            s2_d      <= s2;
            arm_sr    <= {arm_sr[1:0], 1'b1};
            state     <= state_nxt;
            pending_o <= pend_nxt;
            missed_o  <= miss_nxt;
            busy_o    <= (state != ST_IDLE);
`ifdef LED_PWM_EN
            led_o     <= (state == ST_ON) && (pwm_cnt < duty_i);
`else
            led_o     <= (state == ST_ON);
`endif
            // Timebase restarts on every state entry so each phase lasts exactly N ticks
            if (entry || state == ST_IDLE) begin
                presc <= '0;
                dur   <= '0;
            end else if (tick) begin
                presc <= '0;
                dur   <= dur + DUR_W'(1);
            end else begin
                presc <= presc + PRE_W'(1);
            end
        end
    end

`ifdef LED_PWM_EN
    always_ff @(posedge clk) begin
        if (rst) pwm_cnt <= '0;
        else     pwm_cnt <= pwm_cnt + 4'd1;
    end
`endif

endmodule
